// File: rtl/reg_pkg.sv
// Shared types and constants for the Register A read path.
package reg_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_HOLD} rd_state_t;

  localparam int unsigned DEFAULT_PIPE_DEPTH = 2;

endpackage

// File: rtl/reg_a_reader.sv
// Read-side companion to Register A: waits out the load-to-output latency, captures the settled
// value and returns it on a valid/ready response channel.
module reg_a_reader
  import reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIPE_DEPTH = DEFAULT_PIPE_DEPTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  load_mon,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 15) begin : g_bad_depth
    $fatal(1, "reg_a_reader: PIPE_DEPTH must be within 1..15");
  end

  localparam logic [3:0] WaitInit = 4'(PIPE_DEPTH);

  rd_state_t             state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      wait_cnt_q <= '0;
      rsp_data_q <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rsp_data_q <= rsp_data_d;
      rd_count_q <= rd_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rsp_data_d = rsp_data_q;
    rd_count_d = rd_count_q;

    unique case (state_q)
      RD_IDLE: begin
        if (req_valid) begin
          state_d    = RD_WAIT;
          wait_cnt_d = WaitInit;
        end
      end
      RD_WAIT: begin
        // A fresh load restarts the settle window; it wins over a capture due this edge.
        if (load_mon) begin
          wait_cnt_d = WaitInit;
        end else if (wait_cnt_q == 4'd1) begin
          rsp_data_d = data_in;
          state_d    = RD_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RD_HOLD: begin
        if (rsp_ready) begin
          state_d    = RD_IDLE;
          rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign req_ready = (state_q == RD_IDLE);
  assign rsp_valid = (state_q == RD_HOLD);
  assign busy      = (state_q != RD_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rd_count  = rd_count_q;

endmodule

// File: tb/tb_reg_a_reader.sv
// Bench for reg_a_reader: timestamp-based reference model plus directed scenarios.
module tb_reg_a_reader;

  localparam int unsigned Pipe = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        load_a = 1'b0;
  logic [31:0] din_a = '0;
  logic [31:0] data_drv = '0;
  logic        use_rega = 1'b0;
  logic [31:0] rega_s1 = '0;
  logic [31:0] rega_s2 = '0;
  logic [31:0] data_in;

  logic        req_ready, rsp_valid, busy;
  logic [31:0] rsp_data;
  logic [15:0] rd_count;
  logic        req_ready2, rsp_valid2, busy2;
  logic [31:0] rsp_data2;
  logic [3:0]  rd_count2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Two-stage stand-in for the Register A pipeline.
  always @(posedge clk) begin
    if (load_a) rega_s1 <= din_a;
    rega_s2 <= rega_s1;
  end

  assign data_in = use_rega ? rega_s2 : data_drv;

  reg_a_reader #(.DATA_WIDTH(32), .PIPE_DEPTH(Pipe), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .load_mon(load_a), .data_in(data_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .rd_count(rd_count)
  );

  reg_a_reader #(.DATA_WIDTH(32), .PIPE_DEPTH(Pipe), .CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .load_mon(load_a), .data_in(data_in), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data2), .busy(busy2), .rd_count(rd_count2)
  );

  // Reference model: absolute edge timestamps for the capture deadline.
  int          edge_n = 0;
  int          cap_edge = 0;
  bit          m_wait = 0;
  bit          m_hold = 0;
  logic [31:0] m_data = '0;
  int          m_count = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wait = 0; m_hold = 0; m_data = '0; m_count = 0;
    end else begin
      edge_n++;
      if (m_hold) begin
        if (rsp_ready) begin m_hold = 0; m_count++; end
      end else if (m_wait) begin
        if (load_a) cap_edge = edge_n + Pipe;
        else if (edge_n == cap_edge) begin m_data = data_in; m_hold = 1; m_wait = 0; end
      end else if (req_valid) begin
        m_wait = 1; cap_edge = edge_n + Pipe;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic [15:0] exp_cnt;
      logic [3:0]  exp_cnt4;
      exp_cnt  = 16'(m_count);
      exp_cnt4 = 4'(m_count);
      n_checks++;
      if (rsp_valid !== m_hold || req_ready !== !(m_wait || m_hold) ||
          busy !== (m_wait || m_hold) || rsp_data !== m_data || rd_count !== exp_cnt ||
          rsp_valid2 !== m_hold || rsp_data2 !== m_data || rd_count2 !== exp_cnt4) begin
        n_fail++;
        $display("FAIL model t=%0t: got v=%b rdy=%b busy=%b data=%h cnt=%0d cnt4=%0d; want v=%b rdy=%b busy=%b data=%h cnt=%0d cnt4=%0d",
                 $time, rsp_valid, req_ready, busy, rsp_data, rd_count, rd_count2,
                 m_hold, !(m_wait || m_hold), (m_wait || m_hold), m_data, exp_cnt, exp_cnt4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 1);
    chk("reset rd_count", 32'(rd_count), 0);
    chk("reset rsp_data", rsp_data, 0);

    // Basic read
    data_drv = 32'hA5A5_0001; rsp_ready = 1'b1; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    chk("basic busy E0", 32'(busy), 1);
    tick();
    chk("basic no early rsp", 32'(rsp_valid), 0);
    tick();
    chk("basic rsp_valid", 32'(rsp_valid), 1);
    chk("basic rsp_data", rsp_data, 32'hA5A5_0001);
    tick();
    chk("basic rd_count", 32'(rd_count), 1);
    chk("basic back idle", 32'(req_ready), 1);

    // Load during wait, through the register pipeline
    use_rega = 1'b1; load_a = 1'b1; din_a = 32'h1111_2222;
    tick(); load_a = 1'b0;
    tick(); tick();
    req_valid = 1'b1;
    tick(); req_valid = 1'b0; load_a = 1'b1; din_a = 32'hDEAD_BEEF;
    tick(); load_a = 1'b0;
    tick();
    chk("load no stale capture", 32'(rsp_valid), 0);
    tick();
    chk("load rsp_valid E3", 32'(rsp_valid), 1);
    chk("load rsp_data", rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("load rd_count", 32'(rd_count), 2);

    // Backpressure in HOLD
    use_rega = 1'b0; rsp_ready = 1'b0; data_drv = 32'h0BAD_F00D; req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      data_drv = 32'h1000_0000 + 32'(i); req_valid = 1'b1; load_a = i[0];
      tick();
      chk("bp rsp_valid", 32'(rsp_valid), 1);
      chk("bp rsp_data", rsp_data, 32'h0BAD_F00D);
      chk("bp req_ready", 32'(req_ready), 0);
    end
    load_a = 1'b0; rsp_ready = 1'b1;
    tick(); req_valid = 1'b0;
    chk("bp release idle", 32'(busy), 0);
    chk("bp release count", 32'(rd_count), 3);

    // Back-to-back: 12 edges with req_valid high
    req_valid = 1'b1;
    repeat (12) tick();
    req_valid = 1'b0;
    chk("b2b count", 32'(rd_count), 6);
    chk("b2b idle", 32'(busy), 0);

    // Asynchronous reset while waiting
    req_valid = 1'b1;
    tick(); req_valid = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rd_count", 32'(rd_count), 0);
    chk("rst rd_count4", 32'(rd_count2), 0);
    tick();
    #3 reset = 1'b0;
    tick();
    chk("rst release ready", 32'(req_ready), 1);
    repeat (4) begin
      tick();
      chk("rst no response", 32'(rsp_valid), 0);
    end

    // 17 reads to wrap the 4-bit counter
    for (int i = 0; i < 17; i++) begin
      data_drv = 32'hC000_0000 ^ 32'(i * 7);
      req_valid = 1'b1;
      tick(); req_valid = 1'b0;
      tick(); tick(); tick();
    end
    chk("wrap rd_count16", 32'(rd_count), 17);
    chk("wrap rd_count4", 32'(rd_count2), 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
